// File: rtl/unidad_muldiv_if.sv
// Request/write-back bundle between the core and the RV32M multiply/divide unit.
// The master side is the core: it drives the operands read from the register bank.
// The slave side is the unit: it returns the write-back pulse for the bank's write port.
interface unidad_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] operandA;
    logic [XLEN-1:0] operandB;
    logic [4:0]      rd;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            reg_write;

    modport master (
        output start, funct3, operandA, operandB, rd,
        input  busy, done, result, rd_out, reg_write
    );

    modport slave (
        input  start, funct3, operandA, operandB, rd,
        output busy, done, result, rd_out, reg_write
    );
endinterface

// File: rtl/unidad_muldiv.sv
// Iterative RV32M multiply/divide unit with a fixed 34-cycle latency.
// Operand magnitudes are processed by a shared 64-bit accumulator:
//  - multiply: shift-add, the multiplier rides in the low half and shifts out;
//  - divide: restoring division, the dividend shifts out of the low half and the
//    quotient shifts in behind it, the partial remainder lives in the high half.
// Sign correction, divide-by-zero and result selection happen in FINISH.
module unidad_muldiv #(
    parameter int XLEN = 32
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    unidad_muldiv_if.slave        bus
);
    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mag_b_q, mag_b_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic              b_zero_q, b_zero_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;

    logic              a_signed;
    logic              b_signed;
    logic              in_sign_a;
    logic              in_sign_b;
    logic [XLEN-1:0]   in_mag_a;
    logic [XLEN-1:0]   in_mag_b;

    // One shift-add step: add the multiplicand if the current multiplier bit is set,
    // then shift the {carry, high, low} word right by one.
    function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] acc,
                                                   input logic [XLEN-1:0]   mcand);
        logic [XLEN:0] sum;
        sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
        return {sum, acc[XLEN-1:1]};
    endfunction

    // One restoring-division step: shift the next dividend bit into a 33-bit
    // partial remainder and subtract the divisor if it fits.
    function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] acc,
                                                   input logic [XLEN-1:0]   dvsr);
        logic [XLEN:0] pr;
        logic [XLEN:0] diff;
        pr   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff = pr - {1'b0, dvsr};
        if (!diff[XLEN]) begin
            return {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
        return {pr[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    endfunction

    // Apply sign rules and divide-by-zero override, then pick the architectural result.
    function automatic logic [XLEN-1:0] finalize(input logic [2:0]        f3,
                                                 input logic [2*XLEN-1:0] acc,
                                                 input logic              sa,
                                                 input logic              sb,
                                                 input logic              bz,
                                                 input logic [XLEN-1:0]   opa);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = (sa ^ sb) ? -acc : acc;
        quo  = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (f3)
            F_MUL:                      return prod[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU:  return prod[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:              return bz ? {XLEN{1'b1}} : quo;
            default:                    return bz ? opa : rem;
        endcase
    endfunction

    // Operand decode: which operands are treated as signed, and their magnitudes.
    always_comb begin
        a_signed  = (bus.funct3 == F_MULH) || (bus.funct3 == F_MULHSU) ||
                    (bus.funct3 == F_DIV)  || (bus.funct3 == F_REM);
        b_signed  = (bus.funct3 == F_MULH) || (bus.funct3 == F_DIV) ||
                    (bus.funct3 == F_REM);
        in_sign_a = a_signed & bus.operandA[XLEN-1];
        in_sign_b = b_signed & bus.operandB[XLEN-1];
        in_mag_a  = in_sign_a ? -bus.operandA : bus.operandA;
        in_mag_b  = in_sign_b ? -bus.operandB : bus.operandB;
    end

    // Next-state logic for the IDLE -> CALC -> FINISH sequence and the datapath.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mag_b_d  = mag_b_q;
        opa_d    = opa_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        b_zero_d = b_zero_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        rd_out_d = rd_out_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    f3_d     = bus.funct3;
                    rd_d     = bus.rd;
                    opa_d    = bus.operandA;
                    sign_a_d = in_sign_a;
                    sign_b_d = in_sign_b;
                    b_zero_d = (bus.operandB == '0);
                    mag_b_d  = in_mag_b;
                    acc_d    = {{XLEN{1'b0}}, in_mag_a};
                    count_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d   = f3_q[2] ? div_step(acc_q, mag_b_q) : mul_step(acc_q, mag_b_q);
                count_d = count_q + 1'b1;
                if (count_q == CNT_LAST) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                result_d = finalize(f3_q, acc_q, sign_a_q, sign_b_q, b_zero_q, opa_q);
                rd_out_d = rd_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mag_b_q  <= '0;
            opa_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            f3_q     <= '0;
            rd_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mag_b_q  <= mag_b_d;
            opa_q    <= opa_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            b_zero_q <= b_zero_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.reg_write = done_q;
    assign bus.result    = result_q;
    assign bus.rd_out    = rd_out_q;
endmodule

// File: tb/tb_unidad_muldiv.sv
// Scoreboard bench for unidad_muldiv: directed RV32M vectors with hand-computed
// results; a negedge monitor pops and checks each write-back pulse and its latency.
module tb_unidad_muldiv;
    logic CLK;
    logic RESET_N;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          e0;
        string       name;
    } exp_t;

    exp_t sb[$];

    unidad_muldiv_if #(.XLEN(32)) bus_if ();

    unidad_muldiv #(.XLEN(32)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write-back pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RESET_N && (bus_if.done || bus_if.reg_write)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_done: done=%0b reg_write=%0b with no request outstanding (cycle %0d)",
                         bus_if.done, bus_if.reg_write, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"},    bus_if.result,            e.res);
                chk({e.name, "_rd_out"},    32'(bus_if.rd_out),       32'(e.rd));
                chk({e.name, "_reg_write"}, 32'(bus_if.reg_write),    32'd1);
                chk({e.name, "_busy_low"},  32'(bus_if.busy),         32'd0);
                chk({e.name, "_latency"},   32'(cyc - e.e0),          32'd33);
            end
        end
    end

    // Present a request now; it is sampled at the next rising edge (E0).
    task automatic issue_core(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input logic [31:0] exp, input string name,
                              input bit push);
        exp_t e;
        bus_if.funct3   = f3;
        bus_if.operandA = a;
        bus_if.operandB = b;
        bus_if.rd       = rd;
        bus_if.start    = 1'b1;
        @(posedge CLK);
        #1;
        bus_if.start    = 1'b0;
        bus_if.operandA = 32'hDEADBEEF;
        bus_if.operandB = 32'hCAFEF00D;
        bus_if.funct3   = 3'b000;
        bus_if.rd       = 5'd31;
        if (push) begin
            e.res  = exp;
            e.rd   = rd;
            e.e0   = cyc;
            e.name = name;
            sb.push_back(e);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input string name);
        @(posedge CLK);
        #1;
        issue_core(f3, a, b, rd, exp, name, 1'b1);
    endtask

    // Wait (bounded) until every outstanding expectation has been retired.
    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 80) begin
            @(posedge CLK);
            k++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(posedge CLK);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      32'(bus_if.busy),      32'd0);
        chk({tag, "_done"},      32'(bus_if.done),      32'd0);
        chk({tag, "_reg_write"}, 32'(bus_if.reg_write), 32'd0);
        chk({tag, "_result"},    bus_if.result,         32'd0);
        chk({tag, "_rd_out"},    32'(bus_if.rd_out),    32'd0);
    endtask

    initial begin
        int k;
        cyc             = 0;
        n_cmp           = 0;
        n_bad           = 0;
        RESET_N         = 1'b0;
        bus_if.start    = 1'b0;
        bus_if.funct3   = 3'b000;
        bus_if.operandA = '0;
        bus_if.operandB = '0;
        bus_if.rd       = '0;

        repeat (2) @(negedge CLK);
        chk_all_zero("reset");
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;

        // MUL 7 x -3 with busy held across the whole operation
        issue(3'b000, 32'h00000007, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, "mul");
        for (int i = 0; i < 33; i++) begin
            @(negedge CLK);
            chk("mul_busy_high", 32'(bus_if.busy), 32'd1);
        end
        drain();

        // High-half multiplies of all-ones operands
        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'h00000000, "mulh");   drain();
        issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFF, "mulhsu"); drain();
        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFE, "mulhu");  drain();

        // -7 / 2 signed and unsigned
        issue(3'b100, 32'hFFFFFFF9, 32'h00000002, 5'd9,  32'hFFFFFFFD, "div");    drain();
        issue(3'b110, 32'hFFFFFFF9, 32'h00000002, 5'd10, 32'hFFFFFFFF, "rem");    drain();
        issue(3'b101, 32'hFFFFFFF9, 32'h00000002, 5'd11, 32'h7FFFFFFC, "divu");   drain();
        issue(3'b111, 32'hFFFFFFF9, 32'h00000002, 5'd12, 32'h00000001, "remu");   drain();

        // Divide by zero (latency checked by the monitor)
        issue(3'b100, 32'h12345678, 32'h00000000, 5'd13, 32'hFFFFFFFF, "div0");   drain();
        issue(3'b101, 32'h12345678, 32'h00000000, 5'd14, 32'hFFFFFFFF, "divu0");  drain();
        issue(3'b110, 32'h12345678, 32'h00000000, 5'd15, 32'h12345678, "rem0");   drain();
        issue(3'b111, 32'h12345678, 32'h00000000, 5'd16, 32'h12345678, "remu0");  drain();

        // Signed overflow
        issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, "div_ovf"); drain();
        issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h00000000, "rem_ovf"); drain();

        // A start pulse in the middle of an operation is ignored
        issue(3'b100, 32'hFFFFFFF9, 32'h00000002, 5'd19, 32'hFFFFFFFD, "div_ignore");
        repeat (9) @(posedge CLK);
        #1;
        bus_if.funct3   = 3'b000;
        bus_if.operandA = 32'd3;
        bus_if.operandB = 32'd4;
        bus_if.rd       = 5'd20;
        bus_if.start    = 1'b1;
        @(posedge CLK);
        #1;
        bus_if.start    = 1'b0;
        drain();

        // Back-to-back: a start during the done cycle is accepted
        issue(3'b111, 32'hFFFFFFF9, 32'h00000002, 5'd3, 32'h00000001, "b2b_first");
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!bus_if.done && k < 50);
        chk("b2b_done_seen", 32'(bus_if.done), 32'd1);
        issue_core(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFE, "b2b_second", 1'b1);
        drain();

        // Reset mid-DIV aborts; the unit restarts on the first edge after release
        issue_core(3'b100, 32'h00000064, 32'h00000007, 5'd21, 32'h0000000E, "div_abort", 1'b0);
        repeat (19) @(posedge CLK);
        #1;
        RESET_N = 1'b0;
        @(negedge CLK);
        chk_all_zero("abort_reset");
        @(posedge CLK);
        @(negedge CLK);
        chk_all_zero("abort_reset_hold");
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        issue_core(3'b011, 32'h80000000, 32'h00000004, 5'd22, 32'h00000002, "mulhu_after_reset", 1'b1);
        drain();
        repeat (40) @(posedge CLK);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
